// File: rtl/vx_tcu_drl_mul_seq.sv
// vx_tcu_drl_mul_seq: feeds N bf16 operand pairs per request through M shared multiplier lanes,
// M pairs per cycle, and collects the N fp32 products into a buffer that is returned with the tag.
// Ports: req_* handshake (operands in, ready out), rsp_* handshake (products and tag out),
// mul_* drive to / result from the combinational lanes, busy while a request is in flight.
module vx_tcu_drl_mul_seq #(
    parameter int N    = 8,
    parameter int M    = 2,
    parameter int TAGW = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [N*16-1:0]   req_a,
    input  logic [N*16-1:0]   req_b,
    input  logic [TAGW-1:0]   req_tag,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [N*32-1:0]   rsp_y,
    output logic [TAGW-1:0]   rsp_tag,
    output logic [M-1:0]      mul_en,
    output logic [M*16-1:0]   mul_a,
    output logic [M*16-1:0]   mul_b,
    input  logic [M*32-1:0]   mul_y,
    output logic              busy
);
    localparam int BEATS = N / M;
    localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t            state_q;
    logic [BW-1:0]     beat_q;
    logic [N*16-1:0]   a_q, b_q;
    logic [N*32-1:0]   y_q;
    logic [TAGW-1:0]   tag_q;
    logic [M*16-1:0]   la, lb;
    logic [M-1:0]      lz;
    logic [M*32-1:0]   ly;
    logic              run;

    assign run       = state_q == RUN;
    assign req_ready = state_q == IDLE;
    assign rsp_valid = state_q == DONE;
    assign busy      = state_q != IDLE;
    assign rsp_y     = y_q;
    assign rsp_tag   = tag_q;

    // Select the M operand pairs belonging to the current beat.
    always_comb begin
        la = '0;
        lb = '0;
        for (int b = 0; b < BEATS; b++)
            if (beat_q == BW'(b)) begin
                la = a_q[b*M*16 +: M*16];
                lb = b_q[b*M*16 +: M*16];
            end
    end

    // A pair with a +/-0 operand never reaches the lane; its product is a signed zero.
    always_comb begin
        lz     = '0;
        ly     = '0;
        mul_en = '0;
        mul_a  = '0;
        mul_b  = '0;
        for (int i = 0; i < M; i++) begin
            lz[i]             = la[i*16 +: 15] == '0 || lb[i*16 +: 15] == '0;
            ly[i*32 +: 32]    = lz[i] ? {la[i*16+15] ^ lb[i*16+15], 31'b0} : mul_y[i*32 +: 32];
            mul_en[i]         = run & ~lz[i];
            mul_a[i*16 +: 16] = mul_en[i] ? la[i*16 +: 16] : 16'h0;
            mul_b[i*16 +: 16] = mul_en[i] ? lb[i*16 +: 16] : 16'h0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            beat_q  <= '0;
            a_q     <= '0;
            b_q     <= '0;
            y_q     <= '0;
            tag_q   <= '0;
        end else begin
            case (state_q)
                IDLE: if (req_valid) begin
                    a_q     <= req_a;
                    b_q     <= req_b;
                    tag_q   <= req_tag;
                    beat_q  <= '0;
                    state_q <= RUN;
                end
                RUN: begin
                    for (int b = 0; b < BEATS; b++)
                        if (beat_q == BW'(b))
                            y_q[b*M*32 +: M*32] <= ly;
                    if (beat_q == BW'(BEATS - 1))
                        state_q <= DONE;
                    else
                        beat_q <= beat_q + BW'(1);
                end
                DONE: if (rsp_ready)
                    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule
